// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if: operand/result handshake bundle for the serial adder/subtractor
interface serial_add_sub_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_sub.sv
// serial_add_sub: multi-cycle add/sub, CHUNK bits per clock LSB-first, carry kept between cycles
module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input logic            clk,
    input logic            rst_n,
    serial_add_sub_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, nxt;
    logic [WIDTH-1:0] a_r, b_r, sum_r;
    logic             carry, cout_r, ovf_r;
    logic [CW-1:0]    count;
    logic [CHUNK-1:0] a_c, b_c, s_c;
    logic             c_out, c_msb, last;
    assign a_c  = a_r[count*CHUNK +: CHUNK];
    assign b_c  = b_r[count*CHUNK +: CHUNK];
    assign {c_out, s_c} = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry};
    // carry into the top bit of the slice, recovered from its sum bit
    assign c_msb = s_c[CHUNK-1] ^ a_c[CHUNK-1] ^ b_c[CHUNK-1];
    assign last  = count == CW'(N - 1);
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.in_valid ? RUN : IDLE;
            RUN:     nxt = last ? DONE : RUN;
            DONE:    nxt = bus.out_ready ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            count  <= '0;
        end else if (state == IDLE && bus.in_valid) begin
            a_r   <= bus.a;
            b_r   <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.cin ^ bus.sub;
            count <= '0;
        end else if (state == RUN) begin
            sum_r[count*CHUNK +: CHUNK] <= s_c;
            carry <= c_out;
            if (last) begin
                cout_r <= c_out;
                ovf_r  <= c_msb ^ c_out;
            end else begin
                count <= count + CW'(1);
            end
        end
    end
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: randomized and directed checks of serial_add_sub at CHUNK=1 and CHUNK=4
module tb_serial_add_sub;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_add_sub_if #(.WIDTH(8)) i1 ();
    serial_add_sub_if #(.WIDTH(8)) i4 ();
    serial_add_sub #(.WIDTH(8), .CHUNK(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));
    serial_add_sub #(.WIDTH(8), .CHUNK(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(i4));

    // {ovf, cout, sum} from signed/unsigned integer arithmetic
    function automatic logic [9:0] model(logic [7:0] a, logic [7:0] b, logic ci, logic su);
        int ua, ub, sa, sb, u, s;
        logic c, v;
        logic [7:0] r;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        if (su) begin
            u = ua - ub - ci; s = sa - sb - ci; c = u >= 0;
        end else begin
            u = ua + ub + ci; s = sa + sb + ci; c = u > 255;
        end
        v = s > 127 || s < -128;
        r = u[7:0];
        return {v, c, r};
    endfunction

    // {in_ready, out_valid, cout, ovf, sum}
    function automatic logic [11:0] obs(int w);
        return w == 4 ? {i4.in_ready, i4.out_valid, i4.cout, i4.ovf, i4.sum}
                      : {i1.in_ready, i1.out_valid, i1.cout, i1.ovf, i1.sum};
    endfunction

    task automatic drive(int w, logic v, logic [7:0] a, logic [7:0] b, logic ci, logic su);
        if (w == 4) begin
            i4.in_valid = v; i4.a = a; i4.b = b; i4.cin = ci; i4.sub = su;
        end else begin
            i1.in_valid = v; i1.a = a; i1.b = b; i1.cin = ci; i1.sub = su;
        end
    endtask

    task automatic set_oready(int w, logic r);
        if (w == 4) i4.out_ready = r;
        else        i1.out_ready = r;
    endtask

    task automatic run_op(int w, logic [7:0] a, logic [7:0] b, logic ci, logic su, string name);
        int n, lat;
        logic [11:0] o;
        logic [9:0] e;
        n = w == 4 ? 2 : 8;
        e = model(a, b, ci, su);
        lat = 0;
        @(negedge clk);
        o = obs(w);
        while (!o[11] && lat < 50) begin
            @(negedge clk); o = obs(w); lat++;
        end
        drive(w, 1'b1, a, b, ci, su);
        @(posedge clk);
        #1 drive(w, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        lat = 0;
        o = obs(w);
        while (!o[10] && lat < 40) begin
            @(posedge clk); lat++; @(negedge clk); o = obs(w);
        end
        compared++;
        if (lat !== n) begin
            mismatched++; $display("FAIL %s latency got %0d want %0d", name, lat, n);
        end
        compared++;
        if (o[7:0] !== e[7:0]) begin
            mismatched++; $display("FAIL %s sum got %h want %h", name, o[7:0], e[7:0]);
        end
        compared++;
        if (o[9] !== e[8]) begin
            mismatched++; $display("FAIL %s cout got %b want %b", name, o[9], e[8]);
        end
        compared++;
        if (o[8] !== e[9]) begin
            mismatched++; $display("FAIL %s ovf got %b want %b", name, o[8], e[9]);
        end
        set_oready(w, 1'b1);
        @(posedge clk);
        #1 set_oready(w, 1'b0);
        o = obs(w);
        compared++;
        if (o[11:10] !== 2'b10) begin
            mismatched++; $display("FAIL %s return_idle rdy/vld got %b want 10", name, o[11:10]);
        end
    endtask

    task automatic test_reset;
        logic [11:0] o;
        run_op(1, 8'hA5, 8'h3C, 1'b1, 1'b0, "pre_reset");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 o = obs(1);
        compared++;
        if (o !== 12'b1000_0000_0000) begin
            mismatched++; $display("FAIL reset rdy,vld,cout,ovf,sum got %b want 100000000000", o);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_add;
        logic [9:0] e;
        e = model(8'h7F, 8'h01, 1'b0, 1'b0);
        compared++;
        if (e !== {1'b1, 1'b0, 8'h80}) begin
            mismatched++; $display("FAIL model_7f01 got %h want 280", e);
        end
        run_op(1, 8'h7F, 8'h01, 1'b0, 1'b0, "add_7f_01");
        run_op(1, 8'hFF, 8'h01, 1'b1, 1'b0, "add_ff_01_c");
    endtask

    task automatic test_sub;
        run_op(1, 8'h05, 8'h07, 1'b0, 1'b1, "sub_05_07");
        run_op(1, 8'h80, 8'h01, 1'b0, 1'b1, "sub_80_01");
    endtask

    task automatic test_random;
        for (int i = 0; i < 16; i++)
            run_op(i % 2 ? 4 : 1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), "random");
    endtask

    task automatic test_backpressure;
        logic [11:0] o;
        logic [7:0] held;
        int lat;
        drive(1, 1'b1, 8'h3A, 8'h5B, 1'b0, 1'b0);
        @(posedge clk);
        #1 drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        lat = 0;
        o = obs(1);
        while (!o[10] && lat < 40) begin
            @(negedge clk); o = obs(1); lat++;
        end
        held = o[7:0];
        compared++;
        if (held !== 8'h95) begin
            mismatched++; $display("FAIL bp_sum got %h want 95", held);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, i == 2, 8'hFF, 8'hFF, 1'b1, 1'b1);
            @(negedge clk);
            o = obs(1);
            compared++;
            if (o[11:10] !== 2'b01 || o[7:0] !== held) begin
                mismatched++;
                $display("FAIL bp_hold rdy/vld got %b want 01 sum got %h want %h", o[11:10], o[7:0], held);
            end
        end
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        set_oready(1, 1'b1);
        @(posedge clk);
        #1 set_oready(1, 1'b0);
        o = obs(1);
        compared++;
        if (o[11:10] !== 2'b10 || o[7:0] !== held) begin
            mismatched++;
            $display("FAIL bp_release rdy/vld got %b want 10 sum got %h want %h", o[11:10], o[7:0], held);
        end
        @(negedge clk);
        o = obs(1);
        compared++;
        if (o[11:10] !== 2'b10) begin
            mismatched++; $display("FAIL bp_ignored rdy/vld got %b want 10", o[11:10]);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [11:0] o;
        @(negedge clk);
        drive(1, 1'b1, 8'hC3, 8'h7E, 1'b1, 1'b0);
        @(posedge clk);
        #1 drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 o = obs(1);
        compared++;
        if (o !== 12'b1000_0000_0000) begin
            mismatched++; $display("FAIL reset_mid_run got %b want 100000000000", o);
        end
        @(negedge clk) rst_n = 1'b1;
        run_op(1, 8'h12, 8'h34, 1'b0, 1'b0, "after_reset_12_34");
        o = obs(1);
        compared++;
        if (o[7:0] !== 8'h46) begin
            mismatched++; $display("FAIL after_reset_sum got %h want 46", o[7:0]);
        end
    endtask

    task automatic test_chunk4;
        run_op(4, 8'h9C, 8'h64, 1'b0, 1'b0, "c4_9c_64");
    endtask

    task automatic test_back_to_back;
        int acc[4];
        int lat;
        logic [11:0] o;
        logic [9:0] e;
        logic [7:0] a, b;
        logic ci, su;
        set_oready(4, 1'b1);
        for (int k = 0; k < 4; k++) begin
            a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom); su = 1'($urandom);
            e = model(a, b, ci, su);
            @(negedge clk);
            lat = 0;
            o = obs(4);
            while (!o[11] && lat < 20) begin
                @(negedge clk); o = obs(4); lat++;
            end
            drive(4, 1'b1, a, b, ci, su);
            @(posedge clk);
            #1 acc[k] = cyc;
            lat = 0;
            o = obs(4);
            while (!o[10] && lat < 20) begin
                @(negedge clk); o = obs(4); lat++;
            end
            compared++;
            if (o[11:10] !== 2'b01 || o[9:0] !== {e[8], e[9], e[7:0]}) begin
                mismatched++;
                $display("FAIL b2b_%0d rdy/vld got %b want 01 cout,ovf,sum got %h want %h",
                         k, o[11:10], o[9:0], {e[8], e[9], e[7:0]});
            end
            if (k > 0) begin
                compared++;
                if (acc[k] - acc[k-1] !== 4) begin
                    mismatched++; $display("FAIL b2b_period got %0d want 4", acc[k] - acc[k-1]);
                end
            end
        end
        drive(4, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        set_oready(4, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        drive(4, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        set_oready(1, 1'b0);
        set_oready(4, 1'b0);
        #12 rst_n = 1'b1;
        test_reset;
        test_add;
        test_sub;
        test_random;
        test_backpressure;
        test_reset_mid_run;
        test_chunk4;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
